// File: rtl/fpa_accumulator.sv
// -----------------------------------------------------------------------------
// fpa_accumulator
//   Streaming IEEE-754 binary32 accumulator. Operand beats arrive on a
//   valid/ready input port and are left-folded into a running sum through a
//   single combinational fpa adder. On the beat flagged last, the packet sum,
//   a saturating beat count and sticky NaN/Inf flags are presented on a
//   valid/ready output port one cycle later.
//
// Handshake rule (both ports): a transfer happens on the rising clk edge where
//   valid and ready are both 1. A source holds valid/data stable until the
//   transfer; ready never depends combinationally on valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (state != DONE)
//   in_data    binary32 operand
//   in_last    marks the final beat of a packet
//   out_valid  packet sum valid
//   out_ready  consumer accepts the sum
//   out_data   binary32 packet sum
//   out_count  beats accepted in the packet, saturating at all-ones
//   out_nan    some intermediate/final sum in the packet was a NaN
//   out_inf    some intermediate/final sum in the packet was an infinity
//   dbg_state  current FSM state (0=IDLE, 1=ACCUM, 2=DONE)
// -----------------------------------------------------------------------------

// fpa: combinational binary32 adder, round-to-nearest-even, full subnormal
// support. Any NaN input, or +Inf plus -Inf, yields the quiet NaN 7FC00000.
// Exact cancellation gives +0; only (-0)+(-0) gives -0.
module fpa (
  input  logic [31:0] number_A,
  input  logic [31:0] number_B,
  output logic [31:0] result
);
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap;
  logic        w_s_big, w_s_small, w_sticky, w_rnd;
  logic [31:0] w_big, w_small;
  logic [8:0]  w_e_big, w_e_small, w_d, w_lz, w_sh, w_e_n, w_e_f;
  logic [26:0] w_m_big, w_m_small, w_m_shift, w_norm;
  logic [27:0] w_sum;
  logic [24:0] w_mant25;
  logic [23:0] w_m_fin;

  always_comb begin
    w_a_nan   = (number_A[30:23] == 8'hFF) && (number_A[22:0] != 23'd0);
    w_b_nan   = (number_B[30:23] == 8'hFF) && (number_B[22:0] != 23'd0);
    w_a_inf   = (number_A[30:23] == 8'hFF) && (number_A[22:0] == 23'd0);
    w_b_inf   = (number_B[30:23] == 8'hFF) && (number_B[22:0] == 23'd0);
    // Order operands by magnitude so the subtraction below never goes negative.
    w_swap    = (number_B[30:0] > number_A[30:0]);
    w_big     = w_swap ? number_B : number_A;
    w_small   = w_swap ? number_A : number_B;
    w_s_big   = w_big[31];
    w_s_small = w_small[31];
    // Subnormals use effective exponent 1 with no hidden bit.
    w_e_big   = (w_big[30:23] == 8'd0)   ? 9'd1 : {1'b0, w_big[30:23]};
    w_e_small = (w_small[30:23] == 8'd0) ? 9'd1 : {1'b0, w_small[30:23]};
    // Three extra low bits carry guard, round and sticky information.
    w_m_big   = {(w_big[30:23] != 8'd0),   w_big[22:0],   3'b000};
    w_m_small = {(w_small[30:23] != 8'd0), w_small[22:0], 3'b000};
    w_d       = w_e_big - w_e_small;

    if (w_d >= 9'd27) begin
      w_m_shift = 27'd0;
      w_sticky  = |w_m_small;
    end else begin
      w_m_shift = w_m_small >> w_d;
      w_sticky  = |(w_m_small & ~({27{1'b1}} << w_d));
    end
    w_m_shift[0] = w_m_shift[0] | w_sticky;

    if (w_s_big == w_s_small) w_sum = {1'b0, w_m_big} + {1'b0, w_m_shift};
    else                      w_sum = {1'b0, w_m_big} - {1'b0, w_m_shift};

    w_lz = 9'd27;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) w_lz = 9'(26 - i);
    end

    w_norm = 27'd0;
    w_e_n  = 9'd0;
    w_sh   = 9'd0;
    if (w_sum[27]) begin
      // Carry out of the add: shift right once, folding the lost bit into sticky.
      w_norm = w_sum[27:1] | {26'd0, w_sum[0]};
      w_e_n  = w_e_big + 9'd1;
    end else begin
      // Left-normalise, but never below effective exponent 1 (subnormal result).
      w_sh   = (w_lz > (w_e_big - 9'd1)) ? (w_e_big - 9'd1) : w_lz;
      w_norm = w_sum[26:0] << w_sh;
      w_e_n  = w_e_big - w_sh;
    end

    w_rnd    = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mant25 = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    if (w_mant25[24]) begin
      w_m_fin = w_mant25[24:1];
      w_e_f   = w_e_n + 9'd1;
    end else begin
      w_m_fin = w_mant25[23:0];
      w_e_f   = w_e_n;
    end

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (number_A[31] != number_B[31])))
      result = 32'h7FC0_0000;
    else if (w_a_inf)
      result = number_A;
    else if (w_b_inf)
      result = number_B;
    else if (w_sum == 28'd0)
      result = {number_A[31] & number_B[31], 31'd0};
    else if (w_e_f >= 9'd255)
      result = {w_s_big, 8'hFF, 23'd0};
    else
      // A clear hidden bit means the result stayed subnormal: exponent field 0.
      result = {w_s_big, (w_m_fin[23] ? w_e_f[7:0] : 8'h00), w_m_fin[22:0]};
  end
endmodule

module fpa_accumulator #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_nan,
  output logic             out_inf,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_nan, r_inf;

  logic [31:0]      w_sum, w_new_acc;
  logic [CNT_W-1:0] w_new_cnt;
  logic             w_accept, w_new_nan, w_new_inf, w_first;

  fpa u_fpa (
    .number_A (r_acc),
    .number_B (in_data),
    .result   (w_sum)
  );

  assign in_ready  = (r_state != S_DONE);
  assign dbg_state = r_state;
  assign w_accept  = in_valid & in_ready;
  assign w_first   = (r_state == S_IDLE);

  // First beat is loaded verbatim so -0 and special values survive untouched.
  assign w_new_acc = w_first ? in_data : w_sum;
  assign w_new_cnt = w_first ? CNT_W'(1) :
                     ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1));
  assign w_new_nan = (w_first ? 1'b0 : r_nan) |
                     ((w_new_acc[30:23] == 8'hFF) && (w_new_acc[22:0] != 23'd0));
  assign w_new_inf = (w_first ? 1'b0 : r_inf) |
                     ((w_new_acc[30:23] == 8'hFF) && (w_new_acc[22:0] == 23'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= 32'd0;
      r_cnt     <= '0;
      r_nan     <= 1'b0;
      r_inf     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_count <= '0;
      out_nan   <= 1'b0;
      out_inf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_new_acc;
            r_cnt <= w_new_cnt;
            r_nan <= w_new_nan;
            r_inf <= w_new_inf;
            if (in_last) begin
              r_state   <= S_DONE;
              out_valid <= 1'b1;
              out_data  <= w_new_acc;
              out_count <= w_new_cnt;
              out_nan   <= w_new_nan;
              out_inf   <= w_new_inf;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
            r_acc     <= 32'd0;
            r_cnt     <= '0;
            r_nan     <= 1'b0;
            r_inf     <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpa_accumulator.sv
module tb_fpa_accumulator;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_nan, out_inf;
  logic [31:0] out_data;
  logic [15:0] out_count;
  logic [1:0]  dbg_state;
  logic        in_ready2, out_valid2, out_nan2, out_inf2;
  logic [31:0] out_data2;
  logic [1:0]  out_count2;
  logic [1:0]  dbg_state2;

  fpa_accumulator #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_nan(out_nan), .out_inf(out_inf), .dbg_state(dbg_state)
  );

  // Narrow-counter copy fed the same stream, used for saturation behaviour.
  fpa_accumulator #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_count(out_count2),
    .out_nan(out_nan2), .out_inf(out_inf2), .dbg_state(dbg_state2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // {nan, inf, count[15:0], data[31:0]}
  logic [49:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model (real arithmetic) ----------------
  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  function automatic real to_real(input logic [31:0] x);
    int  e;
    real v;
    e = int'(x[30:23]);
    if (e == 0) v = real'(x[22:0]) * (2.0 ** (-149));
    else        v = (real'(x[22:0]) + 8388608.0) * (2.0 ** (e - 150));
    return x[31] ? -v : v;
  endfunction

  // Round a double to the nearest binary32 (ties to even).
  function automatic logic [31:0] to_single(input real s);
    logic [63:0] bits, sig, kept, rem, half, r;
    int          e32, shift;
    bits  = $realtobits(s);
    e32   = int'(bits[62:52]) - 1023 + 127;
    sig   = {11'd1, bits[51:0]};
    shift = 29 + ((e32 < 1) ? (1 - e32) : 0);
    if (shift > 60) return {bits[63], 31'd0};
    kept = sig >> shift;
    rem  = sig & ((64'd1 << shift) - 64'd1);
    half = 64'd1 << (shift - 1);
    if ((rem > half) || ((rem == half) && kept[0])) kept = kept + 64'd1;
    r = (64'(((e32 < 1) ? 0 : (e32 - 1))) << 23) + kept;
    if (r >= 64'h7F80_0000) return {bits[63], 8'hFF, 23'd0};
    return {bits[63], r[30:0]};
  endfunction

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    real s;
    if (is_nan(a) || is_nan(b)) return 32'h7FC0_0000;
    if (is_inf(a) && is_inf(b)) return (a[31] == b[31]) ? a : 32'h7FC0_0000;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    s = to_real(a) + to_real(b);
    if (s == 0.0) return (a == 32'h8000_0000 && b == 32'h8000_0000) ? 32'h8000_0000 : 32'd0;
    return to_single(s);
  endfunction

  logic [31:0] m_acc;
  int          m_cnt;
  bit          m_nan, m_inf, m_started;

  task automatic model_reset();
    m_acc = 32'd0; m_cnt = 0; m_nan = 1'b0; m_inf = 1'b0; m_started = 1'b0;
  endtask

  task automatic model_beat(input logic [31:0] d, input bit last);
    m_acc     = m_started ? model_add(m_acc, d) : d;
    m_started = 1'b1;
    m_cnt++;
    m_nan = m_nan | is_nan(m_acc);
    m_inf = m_inf | is_inf(m_acc);
    if (last) begin
      exp_q.push_back({m_nan, m_inf, 16'((m_cnt > 65535) ? 65535 : m_cnt), m_acc});
      model_reset();
    end
  endtask

  // ---------------- driver tasks (entered just after a negedge) ----------------
  task automatic send_beat(input logic [31:0] d, input bit last);
    check("in_ready_before_beat", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_last = last;
    model_beat(d, last);
    @(negedge clk);
    in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
  endtask

  task automatic collect(input int hold);
    logic [49:0] e;
    logic [31:0] ed;
    int          c2;
    check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    ed = e[31:0];
    c2 = (int'(e[47:32]) > 3) ? 3 : int'(e[47:32]);
    for (int k = 0; k <= hold; k++) begin
      if (k != 0) @(negedge clk);
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_valid2", 32'(out_valid2), 32'd1);
      check("in_ready_done", 32'(in_ready), 32'd0);
      if (is_nan(ed)) begin
        check("out_data_nan", 32'(is_nan(out_data)), 32'd1);
        check("out_data2_nan", 32'(is_nan(out_data2)), 32'd1);
      end else begin
        check("out_data", out_data, ed);
        check("out_data2", out_data2, ed);
      end
      check("out_count", 32'(out_count), 32'(e[47:32]));
      check("out_count2", 32'(out_count2), 32'(c2));
      check("out_nan", 32'(out_nan), 32'(e[49]));
      check("out_inf", 32'(out_inf), 32'(e[48]));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_hs", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
    check("dbg_state_idle", 32'(dbg_state), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [7:0] e;
    e = 8'($urandom_range(134, 120));
    return {1'($urandom_range(1, 0)), e, 23'($urandom)};
  endfunction

  // ---------------- directed then random stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_nan", 32'(out_nan), 32'd0);
    check("rst_out_inf", 32'(out_inf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1 + 2 + 0.5 = 3.5
    send_beat(32'h3F80_0000, 1'b0);
    send_beat(32'h4000_0000, 1'b0);
    send_beat(32'h3F00_0000, 1'b1);
    check("tp_sum_3p5", out_data, 32'h4060_0000);
    collect(0);

    // single -0 beat passes through unchanged
    send_beat(32'h8000_0000, 1'b1);
    check("tp_neg_zero", out_data, 32'h8000_0000);
    collect(0);

    // +Inf + -Inf -> NaN, both flags sticky
    send_beat(32'h7F80_0000, 1'b0);
    send_beat(32'hFF80_0000, 1'b1);
    check("tp_inf_nan_flag", 32'({out_nan, out_inf}), 32'd3);
    collect(0);

    // back-pressure: hold the result for 5 cycles, then next packet
    send_beat(32'h3F80_0000, 1'b0);
    send_beat(32'h3F80_0000, 1'b1);
    collect(5);
    send_beat(32'h4040_0000, 1'b1);
    check("tp_after_hold", out_data, 32'h4040_0000);
    collect(0);

    // five ones: 5.0, narrow counter saturates at 3
    for (int i = 0; i < 5; i++) send_beat(32'h3F80_0000, i == 4);
    check("tp_five", out_data, 32'h40A0_0000);
    check("tp_sat_count", 32'(out_count2), 32'd3);
    collect(0);

    // reset mid-packet drops the partial sum
    send_beat(32'h3F80_0000, 1'b0);
    send_beat(32'h3F80_0000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_no_output", 32'(out_valid), 32'd0);
    send_beat(32'h4000_0000, 1'b1);
    check("abort_sum", out_data, 32'h4000_0000);
    check("abort_count", 32'(out_count), 32'd1);
    collect(0);

    // random packets with idle gaps and random back-pressure
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(6, 1);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(3, 0) == 0) begin
          @(negedge clk);
          check("idle_hold_no_output", 32'(out_valid), 32'd0);
        end
        send_beat(rand_operand(), b == len - 1);
      end
      collect($urandom_range(3, 0));
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
